// File: rtl/serial_adder_seq.sv
// serial_adder_seq: multi-cycle WIDTH-bit adder built on one 2-bit `adder`
// slice. Two bits are added per clock, least-significant pair first, with
// the inter-slice carry held in a register.
//
// Optional build macro: SERIAL_ADDER_OVF_EN
//   When defined, adds the `ovf` output (two's-complement signed overflow of
//   a+b+c_in). When undefined, the port and its logic do not exist.

// Two-bit ripple slice: {c_out, s} = a + b + c_in.
module adder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       c_in,
    output logic [1:0] s,
    output logic       c_out
);
    logic [2:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {2'b00, c_in};
    assign s       = total_s[1:0];
    assign c_out   = total_s[2];
endmodule

module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    // An odd or too-small width cannot be split into 2-bit slices.
    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
            $error("serial_adder_seq: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [IDX_W-1:0] idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             busy_r;
    logic             done_r;

    logic             load_s;
    logic             step_s;
    logic             last_s;
    logic [1:0]       slice_a_s;
    logic [1:0]       slice_b_s;
    logic [1:0]       slice_s_s;
    logic             slice_c_s;
    logic [WIDTH-1:0] sum_next_s;

    adder u_adder (
        .a     (slice_a_s),
        .b     (slice_b_s),
        .c_in  (carry_r),
        .s     (slice_s_s),
        .c_out (slice_c_s)
    );

    assign last_s = (idx_r == LAST_IDX);

    // Select the operand pair for the current slice and merge its result into the sum.
    always_comb begin
        slice_a_s  = 2'b00;
        slice_b_s  = 2'b00;
        sum_next_s = sum_r;
        for (int k = 0; k < SLICES; k++) begin
            if (idx_r == IDX_W'(k)) begin
                slice_a_s                = a_r[2*k +: 2];
                slice_b_s                = b_r[2*k +: 2];
                sum_next_s[2*k +: 2]     = slice_s_s;
            end else begin
                slice_a_s  = slice_a_s;
                slice_b_s  = slice_b_s;
                sum_next_s = sum_next_s;
            end
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, per-slice sum/carry update and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            if (load_s) begin
                a_r     <= a;
                b_r     <= b;
                carry_r <= c_in;
                idx_r   <= {IDX_W{1'b0}};
                sum_r   <= {WIDTH{1'b0}};
                c_out_r <= 1'b0;
            end else if (step_s) begin
                sum_r   <= sum_next_s;
                carry_r <= slice_c_s;
                idx_r   <= idx_r + IDX_W'(1);
                if (last_s) begin
                    c_out_r <= slice_c_s;
                end
            end
            busy_r <= (state_next_s == RUN);
            done_r <= (state_next_s == DONE);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // Signed overflow: carry into the MSB (a1^b1^s1 of the last slice) XOR carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (load_s) begin
            ovf_r <= 1'b0;
        end else if (step_s && last_s) begin
            ovf_r <= (slice_a_s[1] ^ slice_b_s[1] ^ slice_s_s[1]) ^ slice_c_s;
        end
    end

    assign ovf = ovf_r;
`endif

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign c_out = c_out_r;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed testbench for serial_adder_seq: an 8-bit instance for the
// functional scenarios and a 2-bit instance swept over all inputs.
`timescale 1ns/1ps

module tb_serial_adder_seq;
    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
    logic       ovf2;
`endif

    int err_cnt;
    int chk_cnt;

    serial_adder_seq #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .c_in  (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .c_out (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder_seq #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .c_in  (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .c_out (cout2)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 8-bit transaction with latency and hold checks.
    task automatic do_add8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                           input logic [7:0] es, input logic ec, input logic eo, input string tag);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'hA5; b8 = 8'h3C; cin8 = ~ic;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, {31'd0, busy8}, 32'd1);
            check({tag, "_nodone"}, {31'd0, done8}, 32'd0);
            tick();
        end
        check({tag, "_done"}, {31'd0, done8}, 32'd1);
        check({tag, "_busy_done"}, {31'd0, busy8}, 32'd0);
        check({tag, "_sum"}, {24'd0, sum8}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, cout8}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
        tick();
        check({tag, "_done_pulse"}, {31'd0, done8}, 32'd0);
        check({tag, "_sum_hold"}, {24'd0, sum8}, {24'd0, es});
        check({tag, "_cout_hold"}, {31'd0, cout8}, {31'd0, ec});
    endtask

    initial begin
        int val;
        logic [2:0] exp3;
        logic       exp_ovf;

        err_cnt = 0;
        chk_cnt = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("idle_busy", {31'd0, busy8}, 32'd0);
            check("idle_done", {31'd0, done8}, 32'd0);
            check("idle_sum", {24'd0, sum8}, 32'd0);
            check("idle_cout", {31'd0, cout8}, 32'd0);
            tick();
        end

        // Wrap-around, then hold for a few cycles
        do_add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wrap_hold_sum", {24'd0, sum8}, 32'd0);
            check("wrap_hold_cout", {31'd0, cout8}, 32'd1);
            check("wrap_hold_done", {31'd0, done8}, 32'd0);
        end

        // Carry-in chain and signed overflow cases
        do_add8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "cin_chain");
        do_add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "neg_ovf");
        do_add8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "plain");

        // Start held high through RUN, operands changed mid-RUN, back-to-back accept in DONE
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        check("b2b_busy1", {31'd0, busy8}, 32'd1);
        tick();
        a8 = 8'h55; b8 = 8'hAA;
        check("b2b_busy2", {31'd0, busy8}, 32'd1);
        tick();
        check("b2b_busy3", {31'd0, busy8}, 32'd1);
        check("b2b_nodone3", {31'd0, done8}, 32'd0);
        tick();
        check("b2b_busy4", {31'd0, busy8}, 32'd1);
        tick();
        check("b2b_done1", {31'd0, done8}, 32'd1);
        check("b2b_sum1", {24'd0, sum8}, 32'h46);
        check("b2b_cout1", {31'd0, cout8}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b2b_busy_second", {31'd0, busy8}, 32'd1);
            check("b2b_gap_nodone", {31'd0, done8}, 32'd0);
        end
        tick();
        check("b2b_done2", {31'd0, done8}, 32'd1);
        check("b2b_sum2", {24'd0, sum8}, 32'hFF);
        check("b2b_cout2", {31'd0, cout8}, 32'd0);
        start8 = 1'b0;
        tick();
        check("b2b_idle_busy", {31'd0, busy8}, 32'd0);
        check("b2b_idle_done", {31'd0, done8}, 32'd0);
        check("b2b_idle_sum", {24'd0, sum8}, 32'hFF);

        // Reset in the second RUN cycle aborts the operation
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        check("abort_pre_busy", {31'd0, busy8}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_sum", {24'd0, sum8}, 32'd0);
        check("abort_cout", {31'd0, cout8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", {31'd0, done8}, 32'd0);
            check("abort_idle_busy", {31'd0, busy8}, 32'd0);
        end
        do_add8(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, "after_abort");

        // Exhaustive sweep of the 2-bit instance
        for (int n = 0; n < 32; n++) begin
            cin2 = n[4];
            a2   = n[3:2];
            b2   = n[1:0];
            exp3 = 3'(n[3:2]) + 3'(n[1:0]) + 3'(n[4]);
            val  = (n[3] ? int'(n[3:2]) - 4 : int'(n[3:2]))
                 + (n[1] ? int'(n[1:0]) - 4 : int'(n[1:0])) + int'(n[4]);
            exp_ovf = (val > 1) || (val < -2);
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            a2 = ~a2; b2 = ~b2; cin2 = ~cin2;
            check("w2_busy", {31'd0, busy2}, 32'd1);
            check("w2_nodone", {31'd0, done2}, 32'd0);
            tick();
            check("w2_done", {31'd0, done2}, 32'd1);
            check("w2_result", {29'd0, cout2, sum2}, {29'd0, exp3});
`ifdef SERIAL_ADDER_OVF_EN
            check("w2_ovf", {31'd0, ovf2}, {31'd0, exp_ovf});
`else
            if (exp_ovf === 1'bx) $display("note: unknown ovf model value");
`endif
            tick();
            check("w2_idle", {31'd0, done2}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
